// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: shift-mode encodings and
// the per-stage control record carried down the pipeline.
package shifter_pkg;

    localparam logic [1:0] SLL_ENC = 2'b00;
    localparam logic [1:0] SRL_ENC = 2'b01;
    localparam logic [1:0] SRA_ENC = 2'b10;
    localparam logic [1:0] ROR_ENC = 2'b11;

    typedef enum logic [1:0] {
        SLL = SLL_ENC,
        SRL = SRL_ENC,
        SRA = SRA_ENC,
        ROR = ROR_ENC
    } shift_mode_t;

    // Width-independent part of a stage register; the top wraps it with
    // data/shamt/tag fields sized by its own N and TAG_W.
    typedef struct packed {
        logic        valid;
        shift_mode_t mode;
        logic        sign;
    } stage_ctrl_t;

endpackage

// File: rtl/shifter_stage.sv
// One barrel-shifter stage: shifts by 2^K in the selected mode when en is set.
// Rotate support is compiled in only with SHIFTER_ROTATE_EN.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 0
) (
    input  logic [N-1:0] data,
    input  logic         en,
    input  shift_mode_t  mode,
    input  logic         sign,
    output logic [N-1:0] result
);

    localparam int S = 2 ** K;

    logic [N-1:0] shifted;

    always_comb begin
        shifted = data;
        case (mode)
            SLL: shifted = data << S;
            SRL: shifted = data >> S;
            // Fill comes from the sign captured at accept, not from the
            // partially shifted word, so every stage extends consistently.
            SRA: shifted = {{S{sign}}, data[N-1:S]};
            ROR: begin
`ifdef SHIFTER_ROTATE_EN
                shifted = {data[S-1:0], data[N-1:S]};
`else
                shifted = data >> S;
`endif
            end
            default: shifted = data;
        endcase
        result = en ? shifted : data;
    end

endmodule

// File: rtl/shifter_pipelined.sv
// Pipelined barrel shifter, one stage per shift-amount bit, valid/ready with
// a global stall. Define SHIFTER_ROTATE_EN to make ROR rotate instead of SRL.
module shifter_pipelined
    import shifter_pkg::*;
#(
    parameter  int N     = 32,
    parameter  int TAG_W = 4,
    localparam int L     = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic [L-1:0]     in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic [L-1:0]     shamt;
        logic [TAG_W-1:0] tag;
        logic [N-1:0]     data;
    } stage_t;

    stage_t       head;
    stage_t       stage_cur  [L];
    stage_t       stage_next [L];
    stage_t       stage_reg  [L];
    logic [N-1:0] shifted    [L];
    logic         stall;

    assign stall    = out_valid && !out_ready;
    assign in_ready = rst && !stall;

    always_comb begin
        head.ctrl.valid = in_valid && in_ready;
        head.ctrl.mode  = shift_mode_t'(in_mode);
        head.ctrl.sign  = in_data[N-1];
        head.shamt      = in_shamt;
        head.tag        = in_tag;
        head.data       = in_data;
    end

    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_cur[gi] = head;
            end else begin : g_rest
                assign stage_cur[gi] = stage_reg[gi-1];
            end

            shifter_stage #(
                .N(N),
                .K(gi)
            ) u_stage (
                .data   (stage_cur[gi].data),
                .en     (stage_cur[gi].shamt[gi]),
                .mode   (stage_cur[gi].ctrl.mode),
                .sign   (stage_cur[gi].ctrl.sign),
                .result (shifted[gi])
            );
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < L; i++) begin
            stage_next[i]      = stage_cur[i];
            stage_next[i].data = shifted[i];
        end
    end

    // Only valid bits and the visible last stage are reset; inner data and
    // tags are don't-care while their valid bit is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < L; i++) begin
                stage_reg[i].ctrl.valid <= 1'b0;
            end
            stage_reg[L-1].data <= '0;
            stage_reg[L-1].tag  <= '0;
        end else if (!stall) begin
            for (int i = 0; i < L; i++) begin
                stage_reg[i] <= stage_next[i];
            end
        end
    end

    assign out_valid = stage_reg[L-1].ctrl.valid;
    assign out_data  = stage_reg[L-1].data;
    assign out_tag   = stage_reg[L-1].tag;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < L; i++) begin
            busy = busy | stage_reg[i].ctrl.valid;
        end
    end

endmodule

// File: tb/tb_shifter_pipelined.sv
// Directed self-checking bench for shifter_pipelined (N=32, five stages).
module tb_shifter_pipelined;

    localparam int N     = 32;
    localparam int TAG_W = 4;
    localparam int L     = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic [L-1:0]     in_shamt;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] stall_exp [5];
    logic [31:0] ror_exp;

    shifter_pipelined #(
        .N     (N),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, observed, expected);
        end
        $display("check %-16s observed=%h expected=%h", name, observed, expected);
    endtask

    task automatic send(input logic [1:0] mode, input logic [31:0] data,
                        input logic [4:0] shamt, input logic [3:0] tag);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        in_shamt = shamt;
        in_tag   = tag;
        step();
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = 2'b00;
        in_tag    = '0;
        out_ready = 1'b1;
        ror_exp   = 32'h0000_0000;
`ifdef SHIFTER_ROTATE_EN
        ror_exp   = 32'h8000_0000;
`endif

        // Reset state
        step(); step(); step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_out_data",  out_data,           32'd0);
        check("rst_out_tag",   {28'b0, out_tag},   32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        rst = 1'b1;
        #1;
        check("post_rst_ready", {31'b0, in_ready}, 32'd1);

        // SRA latency: result visible exactly five cycles after accept
        send(2'b10, 32'h8000_0000, 5'd4, 4'd3);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("lat_not_yet", {31'b0, out_valid}, 32'd0);
            step();
        end
        check("lat_valid", {31'b0, out_valid}, 32'd1);
        check("lat_data",  out_data,           32'hF800_0000);
        check("lat_tag",   {28'b0, out_tag},   32'd3);
        step();
        check("lat_drained", {31'b0, out_valid}, 32'd0);

        // Back-to-back accepts
        send(2'b00, 32'h0000_0001, 5'd31, 4'd1);
        send(2'b01, 32'hF000_0000, 5'd28, 4'd2);
        send(2'b10, 32'h7FFF_FFFF, 5'd31, 4'd3);
        in_valid = 1'b0;
        step(); step();
        check("b2b_v0", {31'b0, out_valid}, 32'd1);
        check("b2b_d0", out_data,           32'h8000_0000);
        check("b2b_t0", {28'b0, out_tag},   32'd1);
        step();
        check("b2b_v1", {31'b0, out_valid}, 32'd1);
        check("b2b_d1", out_data,           32'h0000_000F);
        check("b2b_t1", {28'b0, out_tag},   32'd2);
        step();
        check("b2b_v2", {31'b0, out_valid}, 32'd1);
        check("b2b_d2", out_data,           32'h0000_0000);
        check("b2b_t2", {28'b0, out_tag},   32'd3);
        step();
        check("b2b_done", {31'b0, out_valid}, 32'd0);

        // Fill with five ops, then stall for three cycles
        stall_exp[0] = 32'h0000_0001;
        stall_exp[1] = 32'h0000_0004;
        stall_exp[2] = 32'h0000_000C;
        stall_exp[3] = 32'h0000_0020;
        stall_exp[4] = 32'h0000_0050;
        for (int i = 0; i < 5; i++) begin
            send(2'b00, 32'(i + 1), 5'(i), 4'(i));
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            check("stall_valid",    {31'b0, out_valid}, 32'd1);
            check("stall_data",     out_data,           stall_exp[0]);
            check("stall_tag",      {28'b0, out_tag},   32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("drain_valid", {31'b0, out_valid}, 32'd1);
            check("drain_data",  out_data,           stall_exp[i]);
            check("drain_tag",   {28'b0, out_tag},   32'(i));
            step();
        end
        check("drain_done", {31'b0, out_valid}, 32'd0);

        // Reset with three ops in flight
        send(2'b00, 32'h0000_00FF, 5'd1, 4'd7);
        send(2'b01, 32'h0000_00FF, 5'd2, 4'd8);
        send(2'b10, 32'h8000_00FF, 5'd3, 4'd9);
        in_valid = 1'b0;
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_busy",  {31'b0, busy},      32'd0);
        for (int i = 0; i < 7; i++) begin
            step();
            check("no_stale", {31'b0, out_valid}, 32'd0);
        end

        // ROR by one: rotate or logical depending on build
        send(2'b11, 32'h0000_0001, 5'd1, 4'd5);
        in_valid = 1'b0;
        step(); step(); step(); step();
        check("ror_valid", {31'b0, out_valid}, 32'd1);
        check("ror_data",  out_data,           ror_exp);
        check("ror_tag",   {28'b0, out_tag},   32'd5);
        step();

        // shamt 0 in every mode returns the operand
        for (int m = 0; m < 4; m++) begin
            send(2'(m), 32'hA5A5_A5A5, 5'd0, 4'(8 + m));
        end
        in_valid = 1'b0;
        step();
        for (int m = 0; m < 4; m++) begin
            check("zero_valid", {31'b0, out_valid}, 32'd1);
            check("zero_data",  out_data,           32'hA5A5_A5A5);
            check("zero_tag",   {28'b0, out_tag},   32'(8 + m));
            step();
        end
        check("zero_done", {31'b0, out_valid}, 32'd0);
        check("idle_busy", {31'b0, busy},      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shifter_pipelined.md
# shifter_pipelined

Parametrised, pipelined barrel shifter. It supports logical left, logical right and arithmetic right shifts, plus an optional rotate-right. It uses a valid/ready handshake and one pipeline stage per shift-amount bit, giving full throughput with backpressure. It sits between the ALU operand registers and the writeback mux, and replaces the single-cycle combinational shifters on timing-critical paths.

## Interface
- `N`, default 32: data width; power of two, ≥ 4.
- `L`, default `$clog2(N)`: number of stages, also the latency in cycles; derived, not overridden.
- `TAG_W`, default 4: width of the sideband tag carried alongside each operation.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  an operation is presented.
- `in_ready`  out  1  the pipeline accepts the operation this cycle.
- `in_data`  in  N  operand.
- `in_shamt`  in  L  shift amount, 0..N-1.
- `in_mode`  in  2  `shift_mode_t` value.
- `in_tag`  in  TAG_W  opaque tag, returned unchanged with the result.
- `out_valid`  out  1  a result is presented.
- `out_ready`  in  1  the consumer takes the result.
- `out_data`  out  N  shifted result.
- `out_tag`  out  TAG_W  tag of this result.
- `busy`  out  1  at least one stage holds a valid operation.

## Operation
- Modes:
  - SLL=2'b00: shift left, zero fill.
  - SRL=2'b01: shift right, zero fill.
  - SRA=2'b10: shift right, fill with `in_data[N-1]` as captured at accept.
  - ROR=2'b11: see Configuration.
- Accept: the operation enters stage 0 when `in_valid && in_ready`.
- Stage k (k=0..L-1) shifts by 2^k when the carried `shamt[k]` is 1, otherwise passes the data through.
- Each stage register holds: valid, data, remaining shamt, mode, sign bit, tag.
- Stall is global: `stall = out_valid && !out_ready`. While stalled, every stage register holds and `in_ready = 0`.
- `in_ready = !stall`. It is combinational from `out_valid`/`out_ready` and does not depend on `in_valid`.
- Bubbles are not compressed. The stall holds them in place; this is accepted for simplicity.
- Results leave in acceptance order. No operation is dropped or duplicated.
- `shamt = 0` returns `in_data` unchanged in every mode.
- SRA of a negative operand by N-1 gives all ones; SRA of a non-negative operand by N-1 gives 0.
- `busy` is the OR of all stage valid bits.

## Timing
- Latency is exactly L cycles from accept to `out_valid` when there is no stall; 5 cycles for N=32.
- Throughput is one operation per cycle while `out_ready = 1`.
- The result handshake completes on the cycle where `out_valid && out_ready`. In that cycle the pipeline advances, and a new input can be accepted in the same cycle.
- Each cycle of stall adds exactly one cycle to the latency of every in-flight operation.
- Reset values, taking effect on the clock edge with `rst = 0`:
  - all stage valid bits 0;
  - `out_valid` 0, `out_data` 0, `out_tag` 0;
  - `busy` 0.
- Reset mid-operation discards every in-flight operation. No result appears for them after reset is released.
- While `rst = 0`, `in_ready = 0`. The first accept can occur in the first cycle after `rst` returns to 1.
- Data and tag registers need no reset except in the last stage. Valid bits must be reset.

## Configuration
- Macro: `SHIFTER_ROTATE_EN`.
- Defined: ROR rotates right; bits shifted out at bit 0 re-enter at bit N-1. A 2^k-bit rotate per stage.
- Undefined: ROR behaves exactly as SRL, and no rotate muxing is synthesised.
- SLL, SRL and SRA behave identically in both builds.

## Structure
- Package `shifter_pkg`:
  - `shift_mode_t` enum (SLL, SRL, SRA, ROR);
  - localparam encodings of the enum;
  - `stage_t` packed struct parametrised via macro-free fields sized by the top-level N.
- Sub-module `shifter_stage`:
  - parameters `N` and `K`, the stage index;
  - combinational shift by 2^K for all modes, gated by `shamt[K]`.
- The top instantiates L `shifter_stage` instances in a generate loop and owns all registers and the handshake.

## Test plan
Defaults apply: N=32, L=5, `out_ready = 1` unless stated.
- SRA, `in_data` 0x80000000, shamt 4, tag 3 → `out_data` 0xF8000000, tag 3, `out_valid` exactly 5 cycles after accept.
- Back-to-back accepts, one per cycle:
  - SLL 0x00000001 by 31 → 0x80000000;
  - SRL 0xF0000000 by 28 → 0x0000000F;
  - SRA 0x7FFFFFFF by 31 → 0x00000000.
  - Required: results on three consecutive cycles, in order.
- Fill the pipeline with 5 operations (tags 0..4), then drop `out_ready` for 3 cycles:
  - `in_ready` is 0 and `out_data`/`out_tag` hold for those cycles;
  - tags 0..4 emerge in order with no loss.
- Assert `rst = 0` for one cycle with 3 operations in flight → next cycle `out_valid` = 0 and `busy` = 0; no stale result appears afterwards.
- ROR, 0x00000001 by 1:
  - built with `SHIFTER_ROTATE_EN` → 0x80000000;
  - built without it → 0x00000000.
- shamt 0 in every mode on 0xA5A5A5A5 → 0xA5A5A5A5.
